// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: padder state encoding, block geometry and the initial hash value.
package sha256_pkg;

   typedef enum logic [1:0] {
      FILL = 2'd0,
      PAD  = 2'd1,
      LEN  = 2'd2,
      EMIT = 2'd3
   } state_t;

   localparam int          LEN_W       = 64;
   localparam int          BLOCK_BYTES = 64;
   localparam logic [5:0]  LEN_OFFSET  = 6'd56;
   localparam logic [7:0]  PAD_BYTE    = 8'h80;

   // H0..H7, H0 in the most significant word
   localparam logic [255:0] SHA256_IV = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

endpackage

// File: rtl/sha256_block_buf.sv
// 64-byte block register: byte 0 lands in [511:504], the 64-bit length field in [63:0].
module sha256_block_buf
   import sha256_pkg::*;
(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clr,
   input  logic                     wr_en,
   input  logic [5:0]               wr_idx,
   input  logic [7:0]               wr_byte,
   input  logic                     len_en,
   input  logic [LEN_W-1:0]         len_val,
   output logic [BLOCK_BYTES*8-1:0] blk_data
);

   logic [BLOCK_BYTES*8-1:0] buf_q;

   // ~wr_idx is (63 - wr_idx): byte position counted from the LSB end
   always_ff @(posedge clk) begin
      if (reset || clr) begin
         buf_q <= '0;
      end else begin
         if (wr_en)
            buf_q[{~wr_idx, 3'b000} +: 8] <= wr_byte;
         if (len_en)
            buf_q[LEN_W-1:0] <= len_val;
      end
   end

   assign blk_data = buf_q;

endmodule

// File: rtl/sha256_msg_padder.sv
// Byte-serial SHA-256 message padder producing 512-bit blocks with first/last markers.
//   state | meaning
//   FILL  | accepting message bytes into the block buffer
//   PAD   | writing 0x80 and, if it fits, the bit length
//   LEN   | writing the bit length into an otherwise empty block
//   EMIT  | block presented, waiting for the core to accept it
module sha256_msg_padder
   import sha256_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic [7:0]   din,
   input  logic         din_valid,
   input  logic         din_keep,
   input  logic         din_last,
   output logic         din_ready,
   output logic [511:0] blk_data,
   output logic         blk_valid,
   input  logic         blk_ready,
   output logic         blk_first,
   output logic         blk_last
);

   state_t           state;
   logic [5:0]       idx;
   logic [LEN_W-1:0] bitcnt;
   logic             first_flag;
   logic             pend_pad;
   logic             pend_len;
   logic             beat;
   logic             len_fits;
   logic             buf_clr;
   logic             buf_wr_en;
   logic [7:0]       buf_wr_byte;
   logic             buf_len_en;

   assign din_ready = !reset && (state == FILL) && !pend_pad && !pend_len;
   assign beat      = din_valid && din_ready;
   assign len_fits  = idx < LEN_OFFSET;

   always_comb begin
      buf_clr     = (state == EMIT) && blk_ready;
      buf_wr_en   = 1'b0;
      buf_wr_byte = din;
      buf_len_en  = 1'b0;
      case (state)
         FILL: buf_wr_en = beat && din_keep;
         PAD: begin
            buf_wr_en   = 1'b1;
            buf_wr_byte = PAD_BYTE;
            buf_len_en  = len_fits;
         end
         LEN:     buf_len_en = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= FILL;
         idx        <= '0;
         bitcnt     <= '0;
         first_flag <= 1'b1;
         pend_pad   <= 1'b0;
         pend_len   <= 1'b0;
         blk_valid  <= 1'b0;
         blk_first  <= 1'b0;
         blk_last   <= 1'b0;
      end else begin
         case (state)
            FILL: begin
               if (beat) begin
                  if (din_keep) begin
                     idx    <= idx + 6'd1;
                     bitcnt <= bitcnt + LEN_W'(8);
                  end
                  if (din_keep && idx == 6'd63) begin
                     state     <= EMIT;
                     blk_valid <= 1'b1;
                     blk_first <= first_flag;
                     blk_last  <= 1'b0;
                     pend_pad  <= din_last;
                  end else if (din_last) begin
                     state <= PAD;
                  end
               end
            end
            PAD: begin
               state     <= EMIT;
               blk_valid <= 1'b1;
               blk_first <= first_flag;
               blk_last  <= len_fits;
               pend_len  <= !len_fits;
            end
            LEN: begin
               state     <= EMIT;
               blk_valid <= 1'b1;
               blk_first <= first_flag;
               blk_last  <= 1'b1;
            end
            EMIT: begin
               if (blk_ready) begin
                  blk_valid  <= 1'b0;
                  idx        <= '0;
                  pend_pad   <= 1'b0;
                  pend_len   <= 1'b0;
                  // a finished message re-arms the length and first-block marker
                  first_flag <= blk_last;
                  if (blk_last)
                     bitcnt <= '0;
                  if (pend_pad)
                     state <= PAD;
                  else if (pend_len)
                     state <= LEN;
                  else
                     state <= FILL;
               end
            end
            default: state <= FILL;
         endcase
      end
   end

   sha256_block_buf u_block_buf (
      .clk      (clk),
      .reset    (reset),
      .clr      (buf_clr),
      .wr_en    (buf_wr_en),
      .wr_idx   (idx),
      .wr_byte  (buf_wr_byte),
      .len_en   (buf_len_en),
      .len_val  (bitcnt),
      .blk_data (blk_data)
   );

endmodule

// File: doc/sha256_msg_padder.md
Name: sha256_msg_padder

Overview:
Upstream stage of the SHA-256 core. Takes a byte-serial message stream and applies FIPS 180-4 padding: a 0x80 byte, zero fill, and a 64-bit big-endian bit length. Emits complete 512-bit blocks as sixteen 32-bit words, which feed the core's w0..w15 inputs. Flags mark the first block, where the core loads the IV, and the last block, where the digest is final.

Parameters:
LEN_W, 64, width of the message bit-length counter and of the length field; fixed by the standard and not to be overridden.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
din  in  8  message byte
din_valid  in  1  byte qualifier
din_keep  in  1  1 = din carries a byte; 0 is legal only together with din_last (terminates the message without a byte, e.g. empty message)
din_last  in  1  final beat of the message
din_ready  out  1  padder accepts a beat this cycle
blk_data  out  512  padded block; w0 = [511:480] ... w15 = [31:0]; bytes are big-endian within each word
blk_valid  out  1  block available; drives the core start
blk_ready  in  1  single-cycle accept pulse from the core (its done)
blk_first  out  1  block is the first of its message
blk_last  out  1  block is the final block of its message

Behaviour:
- Reset values: blk_data = 0, blk_valid = 0, blk_first = 0, blk_last = 0, din_ready = 0.
- Internal reset values: state = FILL, byte index = 0, bit count = 0, first flag = 1, pend_pad = 0, pend_len = 0.
- din_ready = 1 only in FILL with no pend flag set; it is combinational from state.
- States:
  - FILL: on each din_valid & din_ready beat with din_keep = 1, write din to byte[idx], idx++, bitcnt += 8.
    - idx reaches 64 with din_last = 0 → EMIT (blk_last = 0).
    - idx reaches 64 with din_last = 1 → EMIT, set pend_pad.
    - din_last with idx < 64 → PAD.
  - PAD (1 cycle): write 0x80 at byte[idx].
    - If idx ≤ 55, also write bitcnt into bytes 56..63 → EMIT with blk_last = 1.
    - Otherwise set pend_len → EMIT with blk_last = 0.
  - LEN (1 cycle): write bitcnt into bytes 56..63 → EMIT with blk_last = 1.
  - EMIT: blk_valid = 1. blk_data, blk_first and blk_last stay stable until blk_ready. On blk_ready:
    - clear the buffer to zero, set idx = 0, clear the first flag;
    - pend_pad → PAD; pend_len → LEN;
    - otherwise → FILL;
    - if the accepted block was last, also bitcnt = 0 and first flag = 1.
- blk_ready is ignored outside EMIT. The buffer is never modified while blk_valid = 1.
- Latency: blk_valid rises 2 clocks after the final-byte handshake in the single-block case. A full 64-byte data block raises blk_valid 1 clock after its 64th byte.
- bitcnt wraps modulo 2^64; no error is flagged.
- Empty message (din_keep = 0, din_last = 1 at idx 0) produces a single block: 0x80, zeros, length 0.
- Reset mid-message or mid-EMIT: the partial message is discarded, all state returns to reset values, and blk_valid drops on the next clock.
- Throughput: 1 byte per clock in FILL; EMIT stalls for as long as the core computes.

Decomposition:
- sha256_pkg holds:
  - state enum {FILL, PAD, LEN, EMIT};
  - BLOCK_BYTES = 64, LEN_OFFSET = 56, PAD_BYTE = 8'h80;
  - the SHA-256 IV constants, shared with the core.
- One sub-module: sha256_block_buf, a 64-byte register array with synchronous clear, single-byte write and 64-bit length-field write. It outputs the 512-bit packed block.

Test Plan:
- "abc" (0x61, 0x62, 0x63 with last on the third) → one block: w0 = 61626380, w1..w14 = 0, w15 = 00000018, first = 1, last = 1. blk_valid 2 clocks after the 0x63 handshake. Feeding the core yields ba7816bf...f20015ad.
- Empty message (din_keep = 0, din_last = 1) → w0 = 80000000, w1..w15 = 0, first = 1, last = 1.
- 56-byte "abcdbcdecdefdefg...nopq" → two blocks:
  - block 1: data followed by 0x80 at byte 56, first = 1, last = 0;
  - block 2: w0..w13 = 0, w14 = 0, w15 = 000001C0, first = 0, last = 1.
- 64 bytes 0x00..0x3F → two blocks:
  - block 1: raw data, last = 0;
  - block 2: w0 = 80000000, w15 = 00000200, last = 1.
  - din_ready stays 0 from the 64th byte until block 2 is accepted.
- Backpressure: hold blk_ready low for 20 clocks on "abc" → blk_valid and blk_data stay constant and din_ready = 0. A pulse of blk_ready returns the padder to FILL with din_ready = 1 one clock later.
- Reset after 30 bytes of a message → outputs at reset values the next clock. A following "abc" produces exactly the first scenario's block with blk_first = 1.
